// File: rtl/lcd_pkg.sv
// Shared constants, RGB565 field layout and scheduler state encoding.
package lcd_pkg;

  // RGB565 pixel word layout
  localparam int RGB_W = 16;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  // Default panel geometry
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_V_ACTIVE = 480;

  // Scanout fetch state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

  function automatic logic [R_W-1:0] pix_r(input logic [RGB_W-1:0] p);
    return p[R_LSB +: R_W];
  endfunction

  function automatic logic [G_W-1:0] pix_g(input logic [RGB_W-1:0] p);
    return p[G_LSB +: G_W];
  endfunction

  function automatic logic [B_W-1:0] pix_b(input logic [RGB_W-1:0] p);
    return p[B_LSB +: B_W];
  endfunction

endpackage

// File: rtl/lcd_pixel_fifo.sv
// Small synchronous prefetch FIFO with flush. Pop on empty is ignored;
// push on full is accepted only when a pop frees the slot in the same cycle.
module lcd_pixel_fifo import lcd_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DW    = RGB_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_ok, push_ok;

  // Next-state for storage, pointers and occupancy; flush wins over push/pop
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/lcd_fb_scheduler.sv
// Framebuffer scheduler: prefetches pixels in raster order from a single-port
// SRAM into a FIFO for scanout and gives leftover SRAM cycles to host writes.
module lcd_fb_scheduler import lcd_pkg::*; #(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   ADDR_W     = 19,
  parameter int   FIFO_DEPTH = 4,
  parameter logic VS_POL     = 1'b0
) (
  input  logic              PIXEL_CLK,
  input  logic              RESET,
  input  logic              HSYNC,
  input  logic              VSYNC,
  input  logic              DEN,
  output logic              HSYNC_OUT,
  output logic              VSYNC_OUT,
  output logic              DEN_OUT,
  output logic [R_W-1:0]    LCD_R,
  output logic [G_W-1:0]    LCD_G,
  output logic [B_W-1:0]    LCD_B,
  input  logic              HOST_VALID,
  output logic              HOST_READY,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [RGB_W-1:0]  HOST_DATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [RGB_W-1:0]  MEM_WDATA,
  input  logic [RGB_W-1:0]  MEM_RDATA,
  output logic              UNDERFLOW
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  // One extra bit so the range check works even when TOTAL == 2^ADDR_W
  localparam logic [ADDR_W:0]   TOTAL_W   = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [CW:0]       DEPTH_W   = (CW+1)'(FIFO_DEPTH);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              inflight_q, inflight_d;
  logic              hsync_out_q, hsync_out_d;
  logic              vsync_out_q, vsync_out_d;
  logic              den_out_q, den_out_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              underflow_q, underflow_d;

  logic              frame_start;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [RGB_W-1:0]  fifo_rdata;
  logic [CW:0]       occupancy;
  logic              rd_issue, host_grant, host_wr, host_in_range;

  lcd_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (RGB_W)
  ) u_fifo (
    .clk   (PIXEL_CLK),
    .rst   (RESET),
    .flush (frame_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (MEM_RDATA),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // Frame-start detect and SRAM arbitration: scanout first, host gets the rest.
  // The delayed VSYNC output doubles as the previous-VSYNC register.
  always_comb begin
    frame_start   = (VSYNC == VS_POL) && (vsync_out_q != VS_POL);
    fifo_empty    = (fifo_count == '0);
    // Count the outstanding read so its return always has a slot
    occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    rd_issue      = (state_q == ST_FETCH) && (occupancy < DEPTH_W) && !frame_start;
    host_in_range = ({1'b0, HOST_ADDR} < TOTAL_W);
    host_grant    = HOST_VALID && !rd_issue;
    host_wr       = host_grant && host_in_range;
    HOST_READY    = host_grant;
    MEM_EN        = rd_issue || host_wr;
    MEM_WE        = host_wr;
    MEM_ADDR      = rd_issue ? fetch_addr_q : (host_wr ? HOST_ADDR : '0);
    MEM_WDATA     = host_wr ? HOST_DATA : '0;
  end

  // Fetch FSM next state; a frame start restarts fetching from any state
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: if (rd_issue && (fetch_addr_q == LAST_ADDR)) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Fetch address, in-flight tracking, FIFO push/pop and output pipeline
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (frame_start)   fetch_addr_d = '0;
    else if (rd_issue) fetch_addr_d = fetch_addr_q + 1'b1;
    inflight_d  = rd_issue;
    // A return landing on a frame start belongs to the old frame
    fifo_push   = inflight_q && !frame_start;
    fifo_pop    = DEN && !fifo_empty;
    hsync_out_d = HSYNC;
    vsync_out_d = VSYNC;
    den_out_d   = DEN;
    rgb_d       = fifo_pop ? fifo_rdata : '0;
    underflow_d = underflow_q || (DEN && fifo_empty);
  end

  // State and output registers
  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      hsync_out_q  <= 1'b0;
      vsync_out_q  <= 1'b0;
      den_out_q    <= 1'b0;
      rgb_q        <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      hsync_out_q  <= hsync_out_d;
      vsync_out_q  <= vsync_out_d;
      den_out_q    <= den_out_d;
      rgb_q        <= rgb_d;
      underflow_q  <= underflow_d;
    end
  end

  assign HSYNC_OUT = hsync_out_q;
  assign VSYNC_OUT = vsync_out_q;
  assign DEN_OUT   = den_out_q;
  assign LCD_R     = pix_r(rgb_q);
  assign LCD_G     = pix_g(rgb_q);
  assign LCD_B     = pix_b(rgb_q);
  assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_lcd_fb_scheduler.sv
// Bench for lcd_fb_scheduler on a 4x2 panel with an SRAM model preloaded
// with word = address. A queue-based model predicts every cycle's outputs.
module tb_lcd_fb_scheduler;

  localparam int H = 4, V = 2, AW = 4, DEPTH = 4, TOTAL = H * V;

  logic clk = 1'b0;
  logic rst;
  logic hs, vs, den;
  logic hs_out, vs_out, den_out;
  logic [4:0] lcd_r;
  logic [5:0] lcd_g;
  logic [4:0] lcd_b;
  logic hv, hr;
  logic [AW-1:0] ha;
  logic [15:0] hd;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic uf;

  int checks = 0, errors = 0;

  lcd_fb_scheduler #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .VS_POL(1'b0)
  ) dut (
    .PIXEL_CLK(clk), .RESET(rst),
    .HSYNC(hs), .VSYNC(vs), .DEN(den),
    .HSYNC_OUT(hs_out), .VSYNC_OUT(vs_out), .DEN_OUT(den_out),
    .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b),
    .HOST_VALID(hv), .HOST_READY(hr), .HOST_ADDR(ha), .HOST_DATA(hd),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
    .UNDERFLOW(uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // SRAM model: 1-cycle read latency, reloaded with word = address on reset
  logic [15:0] sram [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) sram[i] <= 16'(i);
    end else if (mem_en && mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? sram[mem_addr] : 16'hDEAD;
  end

  // Model state
  logic [15:0] m_fifo [$];
  logic [15:0] m_infl_data;
  logic [15:0] e_rgb;
  bit m_infl, m_fetch, m_uf, m_vs_prev, e_den, e_hs, e_vs;
  int m_next, rd_cnt;
  logic [15:0] pix_q [$];

  // Per-cycle compare at the falling edge, then advance the model
  always @(negedge clk) begin : cmp
    bit fs, rd, hw, inr;
    if (rst) begin
      chk("rst_den_out", den_out, 0);
      chk("rst_hs_out", hs_out, 0);
      chk("rst_vs_out", vs_out, 0);
      chk("rst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
      chk("rst_uf", uf, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_host_ready", hr, 0);
      m_fifo.delete();
      m_infl = 0; m_fetch = 0; m_uf = 0; m_vs_prev = 0; m_next = 0;
      e_den = 0; e_hs = 0; e_vs = 0; e_rgb = '0;
    end else begin
      fs = (vs == 1'b0) && m_vs_prev;
      chk("den_out", den_out, e_den);
      chk("hs_out", hs_out, e_hs);
      chk("vs_out", vs_out, e_vs);
      chk("rgb", {lcd_r, lcd_g, lcd_b}, e_rgb);
      chk("underflow", uf, m_uf);
      if (den_out) pix_q.push_back({lcd_r, lcd_g, lcd_b});
      // Scanout owns the SRAM while fetching and the FIFO plus pending read has room
      rd  = m_fetch && ((m_fifo.size() + int'(m_infl)) < DEPTH) && !fs;
      hw  = !rd && hv;
      inr = (int'(ha) < TOTAL);
      chk("mem_en", mem_en, rd || (hw && inr));
      chk("mem_we", mem_we, hw && inr);
      chk("host_ready", hr, hw);
      if (rd) chk("rd_addr", mem_addr, m_next);
      if (hw && inr) begin
        chk("wr_addr", mem_addr, ha);
        chk("wr_data", mem_wdata, hd);
      end
      e_den = den; e_hs = hs; e_vs = vs;
      if (den) begin
        if (m_fifo.size() > 0) e_rgb = m_fifo.pop_front();
        else begin e_rgb = '0; m_uf = 1; end
      end else e_rgb = '0;
      if (fs) begin
        m_fifo.delete(); m_infl = 0; m_next = 0; m_fetch = 1;
        pix_q.delete(); rd_cnt = 0;
      end else begin
        if (m_infl) m_fifo.push_back(m_infl_data);
        m_infl = rd;
        if (rd) begin
          m_infl_data = sram[m_next];
          m_next++; rd_cnt++;
          if (m_next == TOTAL) m_fetch = 0;
        end
      end
      m_vs_prev = vs;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic line();
    hs = 0; step(); hs = 1; step(); step();
    den = 1; repeat (H) step();
    den = 0; step(); step();
  endtask

  task automatic frame_body();
    repeat (6) step();
    repeat (V) line();
    repeat (4) step();
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp [8]);
    chk({tag, "_npix"}, pix_q.size(), 8);
    if (pix_q.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("%s_pix%0d", tag, i), pix_q[i], exp[i]);
  endtask

  logic [15:0] exp_plain [8];
  logic [15:0] exp_red5  [8];

  initial begin
    exp_plain = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    exp_red5  = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hF800, 16'h0006, 16'h0007};
    rst = 1; hs = 1; vs = 1; den = 0; hv = 0; ha = '0; hd = '0;
    repeat (3) step();
    rst = 0;
    repeat (4) step();
    @(negedge clk); chk("idle_no_fetch", mem_en, 0);

    // Plain frame: raster order, exactly one read per pixel
    vs = 0; step(); vs = 1; step();
    frame_body();
    check_frame("f1", exp_plain);
    chk("f1_reads", rd_cnt, 8);
    @(negedge clk); chk("done_no_fetch", mem_en, 0);

    // Host write held across a frame; only leftover cycles granted
    hv = 1; ha = 4'd5; hd = 16'hF800;
    vs = 0; step(); vs = 1; step();
    frame_body();
    hv = 0;
    chk("f2_reads", rd_cnt, 8);
    chk("sram5", sram[5], 16'hF800);

    // Out-of-range host write is acknowledged but never reaches the SRAM
    hv = 1; ha = 4'd8; hd = 16'h1234;
    @(negedge clk);
    chk("oor_ready", hr, 1);
    chk("oor_mem_en", mem_en, 0);
    step(); hv = 0; step();
    chk("oor_sram8", sram[8], 16'h0008);

    // Second VSYNC edge right after the first read: return must be dropped
    vs = 0; step(); vs = 1;
    @(negedge clk);
    chk("pre_flush_rd_en", mem_en, 1);
    chk("pre_flush_rd_addr", mem_addr, 0);
    step();
    vs = 0; step(); vs = 1; step();
    frame_body();
    check_frame("f3", exp_red5);
    chk("f3_reads", rd_cnt, 8);
    chk("f3_r5", pix_q.size() == 8 ? 32'(pix_q[5][15:11]) : 32'hFFFF, 31);

    // Reset in the middle of a fill
    vs = 0; step(); vs = 1; repeat (4) step();
    rst = 1;
    @(negedge clk);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
    step(); rst = 0;
    repeat (5) step();
    @(negedge clk); chk("midrst_idle", mem_en, 0);

    // DEN one cycle after frame start starves the first pixels
    vs = 0; step(); vs = 1; den = 1; step();
    @(negedge clk);
    chk("uf_den_out", den_out, 1);
    chk("uf_rgb", {lcd_r, lcd_g, lcd_b}, 0);
    chk("uf_set", uf, 1);
    step(); den = 0;
    repeat (6) step();
    chk("uf_sticky", uf, 1);
    rst = 1; step(); rst = 0; step();
    chk("uf_cleared", uf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
